mem_stream_master: RTL



---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_addr_gen.sv | 34 +++
 rtl/mem_stream_master.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared widths and FSM state type for the mem bus
// and the stream master that drives it.
package mem_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WDATA,
    S_REQ,
    S_HOLD,
    S_DONE
  } mem_master_state_t;
endpackage

// File: rtl/mem_addr_gen.sv
// Burst address incrementer and remaining-word
// down-counter with last-word flag.
module mem_addr_gen #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  input  logic                     i_step,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [ADDRESS_WIDTH:0]   i_len,
  output logic [ADDRESS_WIDTH-1:0] o_addr,
  output logic                     o_last
);
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH:0]   r_remaining;

  // Address wraps modulo 2^ADDRESS_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= i_addr;
      r_remaining <= i_len;
    end else if (i_step) begin
      r_addr      <= r_addr + ADDRESS_WIDTH'(1);
      r_remaining <= r_remaining - (ADDRESS_WIDTH + 1)'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_remaining == (ADDRESS_WIDTH + 1)'(1));
endmodule

// File: rtl/mem_stream_master.sv
// Burst master bridging command + valid/ready
// streams onto the mem sel/w_en/ready bus.
module mem_stream_master #(
  parameter int DATA_WIDTH    = mem_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = mem_pkg::ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [ADDRESS_WIDTH:0]   cmd_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     done,
  output logic                     mem_sel,
  output logic                     mem_w_en,
  output logic [ADDRESS_WIDTH-1:0] mem_address_bus,
  inout  wire  [DATA_WIDTH-1:0]    mem_data_bus,
  input  logic                     mem_ready
);
  import mem_pkg::*;

  mem_master_state_t r_state;
  mem_master_state_t w_next;

  logic                     r_dir;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_rd_data;
  logic                     w_accept;
  logic                     w_wr_take;
  logic                     w_rd_cap;
  logic                     w_step;
  logic                     w_last;
  logic                     w_drive;
  logic [ADDRESS_WIDTH-1:0] w_addr;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_wr_take = (r_state == S_WAIT_WDATA) && wr_valid;
  assign w_rd_cap  = (r_state == S_REQ) && mem_ready && !r_dir;
  assign w_step    = ((r_state == S_REQ) && mem_ready && r_dir)
                  || ((r_state == S_HOLD) && rd_ready);

  mem_addr_gen #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_step (w_step),
    .i_addr (cmd_addr),
    .i_len  (cmd_len),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dir     <= 1'b0;
      r_wdata   <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)  r_dir     <= cmd_write;
      if (w_wr_take) r_wdata   <= wr_data;
      if (w_rd_cap)  r_rd_data <= mem_data_bus;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0)  w_next = S_DONE;
          else if (cmd_write) w_next = S_WAIT_WDATA;
          else                w_next = S_REQ;
        end
      end
      S_WAIT_WDATA: begin
        wr_ready = 1'b1;
        if (wr_valid) w_next = S_REQ;
      end
      S_REQ: begin
        if (mem_ready) begin
          if (!r_dir)     w_next = S_HOLD;
          else if (w_last) w_next = S_DONE;
          else            w_next = S_WAIT_WDATA;
        end
      end
      S_HOLD: begin
        rd_valid = 1'b1;
        if (rd_ready) w_next = w_last ? S_DONE : S_REQ;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // sel drops in the ready cycle so mem won't re-capture the stale address.
  assign mem_sel         = (r_state == S_REQ) && !mem_ready;
  assign mem_w_en        = r_dir;
  assign mem_address_bus = w_addr;
  assign rd_data         = r_rd_data;

  assign w_drive      = r_dir && (r_state == S_REQ);
  assign mem_data_bus = w_drive ? r_wdata : 'z;
endmodule
